pc_sequencer: RTL and testbench

//   Fetch/branch controller driving the pc block's control inputs. Requests an

---
 rtl/pc_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer between imem and pc: fetches over req/ack, decodes, and issues one pc pulse per instruction.
// Optional fetch timeout (err + HALT after TIMEOUT ack-less FETCH cycles) is enabled by defining PCSEQ_TIMEOUT_EN.
module pc_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_zflag,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_data,
    input  logic [15:0] i_pc,
    output logic        o_pc_inc,
    output logic        o_pc_add,
    output logic        o_pc_sub,
    output logic [15:0] o_pc_offset,
    output logic        o_busy,
    output logic        o_halt,
    output logic [15:0] o_retired,
    output logic        o_err
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IMM_W  = 12;
    localparam int unsigned OP_LSB = 12;

    localparam logic [3:0] OP_BRF  = 4'h1;
    localparam logic [3:0] OP_BRB  = 4'h2;
    localparam logic [3:0] OP_HALT = 4'h3;
    localparam logic [3:0] OP_BZ   = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   w_ir_nxt;
    logic [DATA_W-1:0]   r_retired;
    logic [DATA_W-1:0]   w_retired_nxt;
    logic [DATA_W-1:0]   r_pc_offset;
    logic [DATA_W-1:0]   w_pc_offset_nxt;
    logic                r_imem_req;
    logic                w_imem_req_nxt;
    logic                r_pc_inc;
    logic                w_pc_inc_nxt;
    logic                r_pc_add;
    logic                w_pc_add_nxt;
    logic                r_pc_sub;
    logic                w_pc_sub_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_halt;
    logic                w_halt_nxt;
    logic [3:0]          w_op;
    logic [DATA_W-1:0]   w_imm;

`ifdef PCSEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                r_err;
    logic                w_err_nxt;
`endif

    // pc is a debug-only input and the immediate is consumed from imem_data on the ack edge
    logic w_unused;
    assign w_unused = ^{i_pc, r_ir[IMM_W-1:0], 32'(TIMEOUT)};

    assign w_op  = i_imem_data[DATA_W-1:OP_LSB];
    assign w_imm = DATA_W'(i_imem_data[IMM_W-1:0]);

    // Next state plus next values of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_ir_nxt        = r_ir;
        w_retired_nxt   = r_retired;
        w_pc_inc_nxt    = 1'b0;
        w_pc_add_nxt    = 1'b0;
        w_pc_sub_nxt    = 1'b0;
        w_pc_offset_nxt = '0;
`ifdef PCSEQ_TIMEOUT_EN
        w_wait_nxt      = r_wait;
        w_err_nxt       = r_err;
`endif

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_imem_ack) begin
                    w_state_nxt = S_EXEC;
                    w_ir_nxt    = i_imem_data;
                    // Pulses are registered on the ack edge so they appear exactly in the EXEC cycle
                    case (w_op)
                        OP_BRF: begin
                            w_pc_add_nxt    = 1'b1;
                            w_pc_offset_nxt = w_imm;
                        end
                        OP_BRB: begin
                            w_pc_sub_nxt    = 1'b1;
                            w_pc_offset_nxt = w_imm;
                        end
                        OP_HALT: begin
                        end
                        OP_BZ: begin
                            if (i_zflag) begin
                                w_pc_add_nxt    = 1'b1;
                                w_pc_offset_nxt = w_imm;
                            end else begin
                                w_pc_inc_nxt    = 1'b1;
                            end
                        end
                        default: begin
                            w_pc_inc_nxt = 1'b1;
                        end
                    endcase
                end
`ifdef PCSEQ_TIMEOUT_EN
                else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = S_HALT;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_wait_nxt  = r_wait + WAIT_W'(1);
                end
`endif
            end
            S_EXEC: begin
                w_retired_nxt = r_retired + DATA_W'(1);
                if (r_ir[DATA_W-1:OP_LSB] == OP_HALT) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef PCSEQ_TIMEOUT_EN
        if ((w_state_nxt == S_FETCH) && (r_state != S_FETCH)) begin
            w_wait_nxt = '0;
        end
`endif

        w_imem_req_nxt = (w_state_nxt == S_FETCH);
        w_busy_nxt     = (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC);
        w_halt_nxt     = (w_state_nxt == S_HALT);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_retired   <= '0;
            r_pc_offset <= '0;
            r_imem_req  <= 1'b0;
            r_pc_inc    <= 1'b0;
            r_pc_add    <= 1'b0;
            r_pc_sub    <= 1'b0;
            r_busy      <= 1'b0;
            r_halt      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ir        <= w_ir_nxt;
            r_retired   <= w_retired_nxt;
            r_pc_offset <= w_pc_offset_nxt;
            r_imem_req  <= w_imem_req_nxt;
            r_pc_inc    <= w_pc_inc_nxt;
            r_pc_add    <= w_pc_add_nxt;
            r_pc_sub    <= w_pc_sub_nxt;
            r_busy      <= w_busy_nxt;
            r_halt      <= w_halt_nxt;
        end
    end

`ifdef PCSEQ_TIMEOUT_EN
    // Fetch wait counter and sticky timeout flag
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= w_wait_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_imem_req  = r_imem_req;
    assign o_pc_inc    = r_pc_inc;
    assign o_pc_add    = r_pc_add;
    assign o_pc_sub    = r_pc_sub;
    assign o_pc_offset = r_pc_offset;
    assign o_busy      = r_busy;
    assign o_halt      = r_halt;
    assign o_retired   = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed and random instruction streams against a pc-arithmetic model.
// Timeout scenarios are exercised when PCSEQ_TIMEOUT_EN is defined.
module tb_pc_sequencer;

    localparam int unsigned TIMEOUT = 15;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        i_zflag;
    logic        o_imem_req;
    logic        i_imem_ack;
    logic [15:0] i_imem_data;
    logic [15:0] i_pc;
    logic        o_pc_inc;
    logic        o_pc_add;
    logic        o_pc_sub;
    logic [15:0] o_pc_offset;
    logic        o_busy;
    logic        o_halt;
    logic [15:0] o_retired;
    logic        o_err;

    int          n_checks;
    int          n_errors;
    logic [15:0] m_pc;
    logic [15:0] m_retired;
    logic        m_err;

    pc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_zflag     (i_zflag),
        .o_imem_req  (o_imem_req),
        .i_imem_ack  (i_imem_ack),
        .i_imem_data (i_imem_data),
        .i_pc        (i_pc),
        .o_pc_inc    (o_pc_inc),
        .o_pc_add    (o_pc_add),
        .o_pc_sub    (o_pc_sub),
        .o_pc_offset (o_pc_offset),
        .o_busy      (o_busy),
        .o_halt      (o_halt),
        .o_retired   (o_retired),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_imem_ack = 1'b0;
        @(posedge clk);
        #1;
        i_reset   = 1'b1;
        m_retired = 16'h0;
        m_err     = 1'b0;
    endtask

    task automatic kick_start();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        n_checks++;
        if ({o_imem_req, o_busy, o_halt, o_err} !== {3'b110, m_err}) begin
            n_errors++;
            $display("FAIL start_to_fetch: req/busy/halt/err got %b expected %b",
                     {o_imem_req, o_busy, o_halt, o_err}, {3'b110, m_err});
        end
    endtask

    // Expected effect of one instruction is derived as pc arithmetic, then compared to what the pulses do to pc
    task automatic run_instr(input logic [15:0] word, input logic z, input int delay);
        logic [3:0]  op;
        logic [15:0] imm;
        logic [15:0] exp_pc;
        logic [15:0] got_pc;
        logic [15:0] exp_off;
        int          exp_cnt;
        int          got_cnt;
        bit          is_halt;
        bit          taken;
        op      = word[15:12];
        imm     = {4'h0, word[11:0]};
        is_halt = (op == 4'h3);
        taken   = (op == 4'h1) || (op == 4'h2) || ((op == 4'h4) && z);
        exp_off = taken ? imm : 16'h0;
        exp_cnt = is_halt ? 0 : 1;
        if (op == 4'h2)   exp_pc = m_pc - imm;
        else if (taken)   exp_pc = m_pc + imm;
        else if (is_halt) exp_pc = m_pc;
        else              exp_pc = m_pc + 16'd1;

        for (int d = 0; d <= delay; d++) begin
            n_checks++;
            if ({o_imem_req, o_busy, o_halt, (o_pc_inc | o_pc_add | o_pc_sub)} !== 4'b1100) begin
                n_errors++;
                $display("FAIL fetch_wait word=%h cycle=%0d: req/busy/halt/pulse got %b expected 1100",
                         word, d, {o_imem_req, o_busy, o_halt, (o_pc_inc | o_pc_add | o_pc_sub)});
            end
            if (d < delay) begin
                i_imem_ack  = 1'b0;
                i_imem_data = 16'($urandom);
                i_zflag     = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end

        i_imem_ack  = 1'b1;
        i_imem_data = word;
        i_zflag     = z;
        @(posedge clk);
        #1;
        // Ack and data during EXEC must be ignored
        i_imem_ack  = 1'($urandom);
        i_imem_data = 16'($urandom);

        got_cnt = int'(o_pc_inc) + int'(o_pc_add) + int'(o_pc_sub);
        got_pc  = m_pc;
        if (o_pc_inc) got_pc = got_pc + 16'd1;
        if (o_pc_add) got_pc = got_pc + o_pc_offset;
        if (o_pc_sub) got_pc = got_pc - o_pc_offset;

        n_checks++;
        if (got_cnt != exp_cnt) begin
            n_errors++;
            $display("FAIL pulse_count word=%h z=%b: got %0d expected %0d", word, z, got_cnt, exp_cnt);
        end
        n_checks++;
        if (got_pc !== exp_pc) begin
            n_errors++;
            $display("FAIL pc_effect word=%h z=%b: pc became %h expected %h", word, z, got_pc, exp_pc);
        end
        n_checks++;
        if (o_pc_offset !== exp_off) begin
            n_errors++;
            $display("FAIL pc_offset word=%h z=%b: got %h expected %h", word, z, o_pc_offset, exp_off);
        end
        n_checks++;
        if ({o_imem_req, o_busy, o_halt, o_retired} !== {3'b010, m_retired}) begin
            n_errors++;
            $display("FAIL exec_status word=%h: req/busy/halt got %b retired %h expected 010 retired %h",
                     word, {o_imem_req, o_busy, o_halt}, o_retired, m_retired);
        end

        m_pc = exp_pc;
        i_pc = m_pc;
        @(posedge clk);
        #1;
        i_imem_ack = 1'b0;
        m_retired  = m_retired + 16'd1;

        n_checks++;
        if (o_retired !== m_retired) begin
            n_errors++;
            $display("FAIL retired word=%h: got %h expected %h", word, o_retired, m_retired);
        end
        n_checks++;
        if ({o_imem_req, o_busy, o_halt, o_pc_inc, o_pc_add, o_pc_sub} !==
            (is_halt ? 6'b001000 : 6'b110000)) begin
            n_errors++;
            $display("FAIL after_exec word=%h: req/busy/halt/pulses got %b expected %b",
                     word, {o_imem_req, o_busy, o_halt, o_pc_inc, o_pc_add, o_pc_sub},
                     (is_halt ? 6'b001000 : 6'b110000));
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_start = 1'b1;
        #3;
        n_checks++;
        if ({o_imem_req, o_pc_inc, o_pc_add, o_pc_sub, o_busy, o_halt, o_err, o_pc_offset, o_retired} !== 39'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: req/inc/add/sub/busy/halt/err got %b offset %h retired %h expected all zero",
                     {o_imem_req, o_pc_inc, o_pc_add, o_pc_sub, o_busy, o_halt, o_err}, o_pc_offset, o_retired);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_imem_req, o_busy, o_halt} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_hold_start: req/busy/halt got %b expected 000", {o_imem_req, o_busy, o_halt});
        end
        i_start = 1'b0;
        i_reset = 1'b1;
    endtask

    task automatic test_start();
        for (int c = 0; c < 4; c++) begin
            i_imem_ack = 1'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if ({o_imem_req, o_busy, o_halt, o_retired} !== 19'h0) begin
                n_errors++;
                $display("FAIL idle_no_start cycle=%0d: req/busy/halt got %b retired %h expected idle",
                         c, {o_imem_req, o_busy, o_halt}, o_retired);
            end
        end
        i_imem_ack = 1'b0;
        kick_start();
    endtask

    task automatic test_directed();
        run_instr(16'h0000, 1'b0, 0);
        run_instr(16'h1005, 1'b0, 0);
        run_instr(16'h2003, 1'b1, 1);
        run_instr(16'h4010, 1'b1, 0);
        run_instr(16'h4010, 1'b0, 2);
        run_instr(16'h1000, 1'b0, 0);
        run_instr(16'h2000, 1'b1, 0);
        run_instr(16'hF123, 1'b1, 0);
        run_instr(16'h7FFF, 1'b0, 1);
        run_instr(16'h1FFF, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [11:0] imm;
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h3) op = 4'h4;
            imm = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
            run_instr({op, imm}, 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_halt();
        do_reset();
        kick_start();
        run_instr(16'h3000, 1'b1, 0);
        for (int c = 0; c < 10; c++) begin
            i_start     = 1'($urandom);
            i_imem_ack  = 1'($urandom);
            i_imem_data = 16'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if ({o_imem_req, o_busy, o_halt, o_pc_inc, o_pc_add, o_pc_sub, o_retired} !== {6'b001000, 16'h0001}) begin
                n_errors++;
                $display("FAIL halt_hold cycle=%0d: req/busy/halt/pulses got %b retired %h expected 001000 retired 0001",
                         c, {o_imem_req, o_busy, o_halt, o_pc_inc, o_pc_add, o_pc_sub}, o_retired);
            end
        end
        i_start    = 1'b0;
        i_imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        kick_start();
        run_instr(16'h0000, 1'b0, 0);
        run_instr(16'h1001, 1'b0, 0);
        @(posedge clk);
        #3;
        i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_imem_req, o_busy, o_halt, o_err, o_retired} !== 20'h0) begin
            n_errors++;
            $display("FAIL reset_mid_fetch: req/busy/halt/err got %b retired %h expected zero",
                     {o_imem_req, o_busy, o_halt, o_err}, o_retired);
        end
        @(posedge clk);
        #1;
        i_reset   = 1'b1;
        m_retired = 16'h0;
        m_err     = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        kick_start();
        i_imem_ack  = 1'b1;
        i_imem_data = 16'h1005;
        @(posedge clk);
        #1;
        i_imem_ack = 1'b0;
        #1;
        i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_pc_inc, o_pc_add, o_pc_sub, o_busy, o_pc_offset, o_retired} !== 36'h0) begin
            n_errors++;
            $display("FAIL reset_mid_exec: inc/add/sub/busy got %b offset %h retired %h expected zero",
                     {o_pc_inc, o_pc_add, o_pc_sub, o_busy}, o_pc_offset, o_retired);
        end
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_imem_req, o_busy, o_halt, o_retired} !== 19'h0) begin
            n_errors++;
            $display("FAIL no_retire_after_exec_reset: req/busy/halt got %b retired %h expected idle, 0000",
                     {o_imem_req, o_busy, o_halt}, o_retired);
        end
    endtask

    task automatic test_fetch_wait();
        do_reset();
        kick_start();
`ifdef PCSEQ_TIMEOUT_EN
        // Ack arriving in the TIMEOUT-th FETCH cycle still completes the fetch
        run_instr(16'h1002, 1'b0, int'(TIMEOUT) - 1);
        for (int c = 1; c <= int'(TIMEOUT); c++) begin
            i_imem_ack  = 1'b0;
            i_imem_data = 16'($urandom);
            @(posedge clk);
            #1;
            if (c < int'(TIMEOUT)) begin
                n_checks++;
                if ({o_imem_req, o_busy, o_halt, o_err} !== 4'b1100) begin
                    n_errors++;
                    $display("FAIL timeout_pending cycle=%0d: req/busy/halt/err got %b expected 1100",
                             c, {o_imem_req, o_busy, o_halt, o_err});
                end
            end
        end
        m_err = 1'b1;
        n_checks++;
        if ({o_imem_req, o_busy, o_halt, o_err, o_retired} !== {4'b0011, m_retired}) begin
            n_errors++;
            $display("FAIL timeout_fire: req/busy/halt/err got %b retired %h expected 0011 retired %h",
                     {o_imem_req, o_busy, o_halt, o_err}, o_retired, m_retired);
        end
        for (int c = 0; c < 5; c++) begin
            i_start    = 1'b1;
            i_imem_ack = 1'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if ({o_imem_req, o_halt, o_err} !== 3'b011) begin
                n_errors++;
                $display("FAIL err_sticky cycle=%0d: req/halt/err got %b expected 011", c, {o_imem_req, o_halt, o_err});
            end
        end
        i_start    = 1'b0;
        i_imem_ack = 1'b0;
`else
        for (int c = 0; c < 40; c++) begin
            i_imem_ack  = 1'b0;
            i_imem_data = 16'($urandom);
            i_zflag     = 1'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if ({o_imem_req, o_busy, o_halt, o_err, o_pc_inc, o_pc_add, o_pc_sub} !== 7'b1100000) begin
                n_errors++;
                $display("FAIL fetch_forever cycle=%0d: req/busy/halt/err/pulses got %b expected 1100000",
                         c, {o_imem_req, o_busy, o_halt, o_err, o_pc_inc, o_pc_add, o_pc_sub});
            end
        end
        run_instr(16'h2004, 1'b0, 0);
`endif
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        m_pc        = 16'h0100;
        m_retired   = 16'h0;
        m_err       = 1'b0;
        i_reset     = 1'b1;
        i_start     = 1'b0;
        i_zflag     = 1'b0;
        i_imem_ack  = 1'b0;
        i_imem_data = 16'h0;
        i_pc        = m_pc;
        #1;
        test_reset();
        test_start();
        test_directed();
        test_random();
        test_halt();
        test_reset_mid_fetch();
        test_reset_mid_exec();
        test_fetch_wait();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
